stage_mem: RTL

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// stage_mem: byte-serial load/store stage between EX/MEM and MEM/WB.
// LOAD/STORE instructions stall the pipeline while bytes are moved one at a
// time through the memory controller; other instructions pass straight through.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned halfword/word
// accesses instead of performing them byte-serially).
module stage_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_din_i,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state, state_d;
  logic [1:0]  cnt, cnt_d;
  logic [31:0] ld_buf;
  logic        cap_pend;
  logic [1:0]  cap_idx;
  logic        is_load, is_store, is_mem;
  logic [1:0]  last_cnt;
  logic        trap_c;
  logic        gnt_ok;
  logic        mis_flag;
  logic [31:0] ld_ext;

  // Instruction decode
  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load | is_store;

  // Index of the last byte: 1, 2 or 4 bytes; unknown widths move a full word
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  // A byte completes only when the stage is live and the controller grants it
  assign gnt_ok = (state == S_XFER) && rdy && mem_gnt_i;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0
  assign trap_c = ((last_cnt == 2'd1) && mem_addr_i[0]) ||
                  ((last_cnt == 2'd3) && (mem_addr_i[1:0] != 2'b00));

  // Remembers that the current DONE cycle is a trap rather than a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (rdy) begin
      mis_q <= (state == S_IDLE) && is_mem && trap_c;
    end
  end

  assign mis_flag = mis_q;
`else
  assign trap_c   = 1'b0;
  assign mis_flag = 1'b0;
`endif

  // Load data extension from the assembled little-endian buffer
  always_comb begin
    case (funct3_i)
      3'b000:  ld_ext = {{24{ld_buf[7]}}, ld_buf[7:0]};
      3'b001:  ld_ext = {{16{ld_buf[15]}}, ld_buf[15:0]};
      3'b100:  ld_ext = {24'd0, ld_buf[7:0]};
      3'b101:  ld_ext = {16'd0, ld_buf[15:0]};
      default: ld_ext = ld_buf;
    endcase
  end

  // State and byte counter; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else if (rdy) begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Load buffer: the byte granted at cnt=k arrives one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_buf   <= 32'd0;
      cap_pend <= 1'b0;
      cap_idx  <= 2'd0;
    end else if (rdy) begin
      if ((state == S_IDLE) && (state_d == S_XFER)) begin
        ld_buf <= 32'd0;
      end else if (cap_pend) begin
        ld_buf[{cap_idx, 3'b000} +: 8] <= mem_din_i;
      end
      cap_pend <= gnt_ok && is_load;
      cap_idx  <= cnt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_a_o     = 32'd0;
    mem_dout_o  = 8'd0;
    stall_req_o = 1'b0;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    misalign_o  = 1'b0;

    case (state)
      S_IDLE: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          cnt_d       = 2'd0;
          state_d     = trap_c ? S_DONE : S_XFER;
        end else begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      S_XFER: begin
        stall_req_o = 1'b1;
        mem_a_o     = mem_addr_i + 32'(cnt);
        if (rdy) begin
          mem_req_o = 1'b1;
          mem_we_o  = is_store;
        end
        if (is_store) begin
          mem_dout_o = 8'(wdata_i >> {cnt, 3'b000});
        end
        if (gnt_ok) begin
          cnt_d = 2'(cnt + 2'd1);
          if (cnt == last_cnt) begin
            state_d = is_store ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_req_o = 1'b1;
        state_d     = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        if (mis_flag) begin
          misalign_o = 1'b1;
        end else if (is_load) begin
          wreg_o  = wreg_i;
          wdata_o = ld_ext;
        end
      end
    endcase

    if (rst) begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_a_o     = 32'd0;
      mem_dout_o  = 8'd0;
      stall_req_o = 1'b0;
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      misalign_o  = 1'b0;
    end
  end

endmodule
